// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared encodings for the writeback stage.
package writeback_stage_pkg;

    localparam logic [1:0] SIZE_8  = 2'd0;
    localparam logic [1:0] SIZE_16 = 2'd1;
    localparam logic [1:0] SIZE_32 = 2'd2;
    localparam logic [1:0] SIZE_32_ALT = 2'd3;

    localparam int NUM_FLAGS = 7;
    localparam int FA_CF = 0;
    localparam int FA_PF = 1;
    localparam int FA_AF = 2;
    localparam int FA_ZF = 3;
    localparam int FA_SF = 4;
    localparam int FA_DF = 5;
    localparam int FA_OF = 6;

    localparam logic [4:0] EF_CF = 5'd0;
    localparam logic [4:0] EF_PF = 5'd2;
    localparam logic [4:0] EF_AF = 5'd4;
    localparam logic [4:0] EF_ZF = 5'd6;
    localparam logic [4:0] EF_SF = 5'd7;
    localparam logic [4:0] EF_DF = 5'd10;
    localparam logic [4:0] EF_OF = 5'd11;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} wb_state_e;

    function automatic logic [4:0] flag_pos(input int i);
        return i == FA_CF ? EF_CF :
               i == FA_PF ? EF_PF :
               i == FA_AF ? EF_AF :
               i == FA_ZF ? EF_ZF :
               i == FA_SF ? EF_SF :
               i == FA_DF ? EF_DF : EF_OF;
    endfunction

    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return s == SIZE_32_ALT ? SIZE_32 : s;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: execute, regfile and dcache signals around the writeback stage.
interface writeback_stage_if #(parameter int CNT_W = 32);
    logic        WB_V_next;
    logic [31:0] WB_NEIP_next;
    logic [15:0] WB_NCS_next;
    logic [1:0]  WB_de_datasize_all_next;
    logic        WB_ex_ld_gpr1_wb_next;
    logic        WB_ex_ld_gpr2_wb_next;
    logic        WB_ld_gpr3_wb_next;
    logic        WB_ex_dcache_write_wb_next;
    logic [6:0]  WB_de_flags_affected_wb_next;
    logic [31:0] WB_RESULT_A_next;
    logic [31:0] WB_RESULT_B_next;
    logic [31:0] WB_RESULT_C_next;
    logic [31:0] WB_FLAGS_next;
    logic [31:0] WB_ADDRESS_next;
    logic [2:0]  WB_DR1_next;
    logic [2:0]  WB_DR2_next;
    logic [2:0]  WB_DR3_next;
    logic        dcache_ack;
    logic        WB_stall;
    logic        gpr_we1;
    logic        gpr_we2;
    logic        gpr_we3;
    logic [2:0]  gpr_sel1;
    logic [2:0]  gpr_sel2;
    logic [2:0]  gpr_sel3;
    logic [31:0] gpr_data1;
    logic [31:0] gpr_data2;
    logic [31:0] gpr_data3;
    logic [1:0]  gpr_size;
    logic        dcache_req;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_data;
    logic [1:0]  dcache_size;
    logic [31:0] eflags;
    logic [31:0] eip_commit;
    logic [15:0] cs_commit;
    logic        CF_dataforwarded;
    logic        AF_dataforwarded;
    logic        retire;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output WB_V_next, WB_NEIP_next, WB_NCS_next, WB_de_datasize_all_next,
               WB_ex_ld_gpr1_wb_next, WB_ex_ld_gpr2_wb_next, WB_ld_gpr3_wb_next,
               WB_ex_dcache_write_wb_next, WB_de_flags_affected_wb_next,
               WB_RESULT_A_next, WB_RESULT_B_next, WB_RESULT_C_next, WB_FLAGS_next,
               WB_ADDRESS_next, WB_DR1_next, WB_DR2_next, WB_DR3_next, dcache_ack,
        input  WB_stall, gpr_we1, gpr_we2, gpr_we3, gpr_sel1, gpr_sel2, gpr_sel3,
               gpr_data1, gpr_data2, gpr_data3, gpr_size, dcache_req, dcache_addr,
               dcache_data, dcache_size, eflags, eip_commit, cs_commit,
               CF_dataforwarded, AF_dataforwarded, retire, retired_count
    );

    modport slave (
        input  WB_V_next, WB_NEIP_next, WB_NCS_next, WB_de_datasize_all_next,
               WB_ex_ld_gpr1_wb_next, WB_ex_ld_gpr2_wb_next, WB_ld_gpr3_wb_next,
               WB_ex_dcache_write_wb_next, WB_de_flags_affected_wb_next,
               WB_RESULT_A_next, WB_RESULT_B_next, WB_RESULT_C_next, WB_FLAGS_next,
               WB_ADDRESS_next, WB_DR1_next, WB_DR2_next, WB_DR3_next, dcache_ack,
        output WB_stall, gpr_we1, gpr_we2, gpr_we3, gpr_sel1, gpr_sel2, gpr_sel3,
               gpr_data1, gpr_data2, gpr_data3, gpr_size, dcache_req, dcache_addr,
               dcache_data, dcache_size, eflags, eip_commit, cs_commit,
               CF_dataforwarded, AF_dataforwarded, retire, retired_count
    );
endinterface

// File: rtl/writeback_stage_flags_update.sv
// wb_flags_update: masked EFLAGS merge and CF/AF forwarding muxes, purely combinational.
import writeback_stage_pkg::*;

module wb_flags_update (
    input  logic        v,
    input  logic [6:0]  mask,
    input  logic [31:0] wb_flags,
    input  logic [31:0] eflags,
    output logic [31:0] eflags_next,
    output logic        cf_fwd,
    output logic        af_fwd
);
    logic [31:0] m;

    // Spread the compact affected-mask onto EFLAGS bit positions.
    always_comb begin
        m = '0;
        for (int i = 0; i < NUM_FLAGS; i++) m[flag_pos(i)] = mask[i];
    end

    assign eflags_next = (eflags & ~m) | (wb_flags & m);
    assign cf_fwd = (v & mask[FA_CF]) ? wb_flags[EF_CF] : eflags[EF_CF];
    assign af_fwd = (v & mask[FA_AF]) ? wb_flags[EF_AF] : eflags[EF_AF];
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: latches execute results, retires them to the GPRs, EFLAGS and dcache.
import writeback_stage_pkg::*;

module writeback_stage #(
    parameter logic [31:0] EFLAGS_RESET = 32'h0000_0002,
    parameter int          CNT_W        = 32
) (
    input logic         CLK,
    input logic         RST,
    writeback_stage_if.slave wb
);
    wb_state_e        state, state_next;
    logic             v, dw, ld1, ld2, ld3, stall, commit;
    logic [31:0]      neip, ra, rb, rc, flags, addr, eflags, eflags_next, eip_c;
    logic [15:0]      ncs, cs_c;
    logic [1:0]       size;
    logic [6:0]       mask;
    logic [2:0]       dr1, dr2, dr3;
    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST) v <= 1'b0;
        else if (!stall) v <= wb.WB_V_next;
    end

    always_ff @(posedge CLK) begin
        if (!stall) begin
            neip  <= wb.WB_NEIP_next;
            ncs   <= wb.WB_NCS_next;
            size  <= wb.WB_de_datasize_all_next;
            ld1   <= wb.WB_ex_ld_gpr1_wb_next;
            ld2   <= wb.WB_ex_ld_gpr2_wb_next;
            ld3   <= wb.WB_ld_gpr3_wb_next;
            dw    <= wb.WB_ex_dcache_write_wb_next;
            mask  <= wb.WB_de_flags_affected_wb_next;
            ra    <= wb.WB_RESULT_A_next;
            rb    <= wb.WB_RESULT_B_next;
            rc    <= wb.WB_RESULT_C_next;
            flags <= wb.WB_FLAGS_next;
            addr  <= wb.WB_ADDRESS_next;
            dr1   <= wb.WB_DR1_next;
            dr2   <= wb.WB_DR2_next;
            dr3   <= wb.WB_DR3_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else state <= state_next;
    end

    // A store being latched always enters WAIT, even straight out of an ack cycle.
    always_comb begin
        state_next = stall ? state :
                     (wb.WB_V_next & wb.WB_ex_dcache_write_wb_next) ? S_WAIT : S_IDLE;
    end

    always_comb begin
        stall  = (state == S_WAIT) & !wb.dcache_ack;
        commit = !RST & v & (!dw | ((state == S_WAIT) & wb.dcache_ack));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            eflags <= EFLAGS_RESET;
            eip_c  <= '0;
            cs_c   <= '0;
            count  <= '0;
        end else if (commit) begin
            eflags <= eflags_next;
            eip_c  <= neip;
            cs_c   <= ncs;
            count  <= count + CNT_W'(1);
        end
    end

    wb_flags_update u_flags (
        .v           (v),
        .mask        (mask),
        .wb_flags    (flags),
        .eflags      (eflags),
        .eflags_next (eflags_next),
        .cf_fwd      (wb.CF_dataforwarded),
        .af_fwd      (wb.AF_dataforwarded)
    );

    assign wb.WB_stall      = stall;
    assign wb.retire        = commit;
    assign wb.gpr_we1       = commit & ld1;
    assign wb.gpr_we2       = commit & ld2;
    assign wb.gpr_we3       = commit & ld3;
    assign wb.gpr_sel1      = dr1;
    assign wb.gpr_sel2      = dr2;
    assign wb.gpr_sel3      = dr3;
    assign wb.gpr_data1     = ra;
    assign wb.gpr_data2     = rb;
    assign wb.gpr_data3     = rc;
    assign wb.gpr_size      = norm_size(size);
    assign wb.dcache_req    = state == S_WAIT;
    assign wb.dcache_addr   = addr;
    assign wb.dcache_data   = ra;
    assign wb.dcache_size   = norm_size(size);
    assign wb.eflags        = eflags;
    assign wb.eip_commit    = eip_c;
    assign wb.cs_commit     = cs_c;
    assign wb.retired_count = count;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed checks of retirement, stores, forwarding and reset.
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_stage_if #(.CNT_W(32)) bus();

    writeback_stage #(.EFLAGS_RESET(32'h0000_0002), .CNT_W(32)) dut (
        .CLK (clk),
        .RST (rst),
        .wb  (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.WB_V_next = 0; bus.WB_NEIP_next = 0; bus.WB_NCS_next = 0;
        bus.WB_de_datasize_all_next = 2'd2; bus.WB_ex_ld_gpr1_wb_next = 0;
        bus.WB_ex_ld_gpr2_wb_next = 0; bus.WB_ld_gpr3_wb_next = 0;
        bus.WB_ex_dcache_write_wb_next = 0; bus.WB_de_flags_affected_wb_next = 0;
        bus.WB_RESULT_A_next = 0; bus.WB_RESULT_B_next = 0; bus.WB_RESULT_C_next = 0;
        bus.WB_FLAGS_next = 0; bus.WB_ADDRESS_next = 0;
        bus.WB_DR1_next = 0; bus.WB_DR2_next = 0; bus.WB_DR3_next = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.dcache_ack = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        checks++; if (bus.eflags !== 32'h2) begin errors++; $display("FAIL reset_eflags got %h want 00000002", bus.eflags); end
        checks++; if (bus.retired_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.retired_count); end
        checks++; if (bus.WB_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.WB_stall); end
        checks++; if ({bus.gpr_we1, bus.gpr_we2, bus.gpr_we3, bus.dcache_req, bus.retire} !== 5'b0) begin errors++; $display("FAIL reset_enables got %b want 00000", {bus.gpr_we1, bus.gpr_we2, bus.gpr_we3, bus.dcache_req, bus.retire}); end
    endtask

    task automatic test_alu();
        clear_inputs();
        bus.WB_V_next = 1; bus.WB_ex_ld_gpr1_wb_next = 1; bus.WB_DR1_next = 3;
        bus.WB_RESULT_A_next = 32'h1234_5678; bus.WB_de_flags_affected_wb_next = 7'b0001001;
        bus.WB_FLAGS_next = 32'h41; bus.WB_NEIP_next = 32'h100; bus.WB_NCS_next = 16'h8;
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.gpr_we1 !== 1'b1) begin errors++; $display("FAIL alu_we1 got %b want 1", bus.gpr_we1); end
        checks++; if (bus.gpr_sel1 !== 3'd3) begin errors++; $display("FAIL alu_sel1 got %0d want 3", bus.gpr_sel1); end
        checks++; if (bus.gpr_data1 !== 32'h1234_5678) begin errors++; $display("FAIL alu_data1 got %h want 12345678", bus.gpr_data1); end
        checks++; if (bus.gpr_we2 !== 1'b0 || bus.gpr_we3 !== 1'b0) begin errors++; $display("FAIL alu_we23 got %b%b want 00", bus.gpr_we2, bus.gpr_we3); end
        checks++; if (bus.retire !== 1'b1) begin errors++; $display("FAIL alu_retire got %b want 1", bus.retire); end
        checks++; if (bus.dcache_req !== 1'b0) begin errors++; $display("FAIL alu_req got %b want 0", bus.dcache_req); end
        tick();
        checks++; if (bus.eflags !== 32'h43) begin errors++; $display("FAIL alu_eflags got %h want 00000043", bus.eflags); end
        checks++; if (bus.retired_count !== 32'd1) begin errors++; $display("FAIL alu_count got %0d want 1", bus.retired_count); end
        checks++; if (bus.eip_commit !== 32'h100 || bus.cs_commit !== 16'h8) begin errors++; $display("FAIL alu_commit got %h:%h want 0008:00000100", bus.cs_commit, bus.eip_commit); end
        checks++; if (bus.retire !== 1'b0) begin errors++; $display("FAIL alu_retire_after got %b want 0", bus.retire); end
    endtask

    task automatic test_store();
        clear_inputs();
        bus.WB_V_next = 1; bus.WB_ex_dcache_write_wb_next = 1;
        bus.WB_ADDRESS_next = 32'h1000; bus.WB_RESULT_A_next = 32'hDEAD_BEEF;
        tick();
        clear_inputs();
        bus.WB_V_next = 1; bus.WB_ex_ld_gpr1_wb_next = 1; bus.WB_DR1_next = 5;
        bus.WB_RESULT_A_next = 32'h55;
        #1;
        checks++; if (bus.dcache_req !== 1'b1 || bus.WB_stall !== 1'b1) begin errors++; $display("FAIL st_c1 req/stall got %b/%b want 1/1", bus.dcache_req, bus.WB_stall); end
        checks++; if (bus.retire !== 1'b0) begin errors++; $display("FAIL st_c1_retire got %b want 0", bus.retire); end
        checks++; if (bus.dcache_addr !== 32'h1000 || bus.dcache_data !== 32'hDEAD_BEEF || bus.dcache_size !== 2'd2) begin errors++; $display("FAIL st_c1_bus got %h/%h/%0d want 00001000/deadbeef/2", bus.dcache_addr, bus.dcache_data, bus.dcache_size); end
        tick();
        checks++; if (bus.dcache_req !== 1'b1 || bus.WB_stall !== 1'b1) begin errors++; $display("FAIL st_c2 req/stall got %b/%b want 1/1", bus.dcache_req, bus.WB_stall); end
        checks++; if (bus.dcache_data !== 32'hDEAD_BEEF || bus.gpr_we1 !== 1'b0) begin errors++; $display("FAIL st_c2_hold got %h/%b want deadbeef/0", bus.dcache_data, bus.gpr_we1); end
        bus.dcache_ack = 1;
        #1;
        checks++; if (bus.dcache_req !== 1'b1 || bus.WB_stall !== 1'b0 || bus.retire !== 1'b1) begin errors++; $display("FAIL st_ack req/stall/retire got %b/%b/%b want 1/0/1", bus.dcache_req, bus.WB_stall, bus.retire); end
        tick();
        bus.dcache_ack = 0;
        clear_inputs();
        #1;
        checks++; if (bus.dcache_req !== 1'b0) begin errors++; $display("FAIL st_after_req got %b want 0", bus.dcache_req); end
        checks++; if (bus.retired_count !== 32'd2) begin errors++; $display("FAIL st_count got %0d want 2", bus.retired_count); end
        checks++; if (bus.gpr_we1 !== 1'b1 || bus.gpr_sel1 !== 3'd5 || bus.gpr_data1 !== 32'h55) begin errors++; $display("FAIL st_next_alu got %b/%0d/%h want 1/5/00000055", bus.gpr_we1, bus.gpr_sel1, bus.gpr_data1); end
        tick();
        checks++; if (bus.retired_count !== 32'd3 || bus.retire !== 1'b0) begin errors++; $display("FAIL st_final count/retire got %0d/%b want 3/0", bus.retired_count, bus.retire); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        bus.dcache_ack = 1;
        bus.WB_V_next = 1; bus.WB_ex_dcache_write_wb_next = 1;
        bus.WB_ADDRESS_next = 32'h2000; bus.WB_RESULT_A_next = 32'h11;
        tick();
        bus.WB_ADDRESS_next = 32'h2004; bus.WB_RESULT_A_next = 32'h22;
        #1;
        checks++; if (bus.retire !== 1'b1 || bus.WB_stall !== 1'b0 || bus.dcache_req !== 1'b1) begin errors++; $display("FAIL b2b_first retire/stall/req got %b/%b/%b want 1/0/1", bus.retire, bus.WB_stall, bus.dcache_req); end
        checks++; if (bus.dcache_addr !== 32'h2000 || bus.dcache_data !== 32'h11) begin errors++; $display("FAIL b2b_first_bus got %h/%h want 00002000/00000011", bus.dcache_addr, bus.dcache_data); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.retire !== 1'b1 || bus.WB_stall !== 1'b0 || bus.dcache_req !== 1'b1) begin errors++; $display("FAIL b2b_second retire/stall/req got %b/%b/%b want 1/0/1", bus.retire, bus.WB_stall, bus.dcache_req); end
        checks++; if (bus.dcache_addr !== 32'h2004 || bus.dcache_data !== 32'h22) begin errors++; $display("FAIL b2b_second_bus got %h/%h want 00002004/00000022", bus.dcache_addr, bus.dcache_data); end
        tick();
        bus.dcache_ack = 0;
        #1;
        checks++; if (bus.dcache_req !== 1'b0 || bus.retire !== 1'b0) begin errors++; $display("FAIL b2b_idle req/retire got %b/%b want 0/0", bus.dcache_req, bus.retire); end
        checks++; if (bus.retired_count !== 32'd5) begin errors++; $display("FAIL b2b_count got %0d want 5", bus.retired_count); end
    endtask

    task automatic test_forward();
        clear_inputs();
        bus.WB_V_next = 1; bus.WB_de_flags_affected_wb_next = 7'b0000101; bus.WB_FLAGS_next = 32'h0;
        tick();
        checks++; if (bus.CF_dataforwarded !== 1'b0) begin errors++; $display("FAIL fwd_a_cf got %b want 0", bus.CF_dataforwarded); end
        bus.WB_V_next = 0; bus.WB_FLAGS_next = 32'h911;
        tick();
        checks++; if (bus.eflags !== 32'h42) begin errors++; $display("FAIL fwd_eflags_a got %h want 00000042", bus.eflags); end
        checks++; if (bus.CF_dataforwarded !== 1'b0 || bus.AF_dataforwarded !== 1'b0) begin errors++; $display("FAIL fwd_v0 cf/af got %b/%b want 0/0", bus.CF_dataforwarded, bus.AF_dataforwarded); end
        bus.WB_V_next = 1;
        tick();
        checks++; if (bus.CF_dataforwarded !== 1'b1 || bus.AF_dataforwarded !== 1'b1) begin errors++; $display("FAIL fwd_v1 cf/af got %b/%b want 1/1", bus.CF_dataforwarded, bus.AF_dataforwarded); end
        checks++; if (bus.eflags !== 32'h42) begin errors++; $display("FAIL fwd_eflags_pre got %h want 00000042", bus.eflags); end
        clear_inputs();
        tick();
        checks++; if (bus.eflags !== 32'h53) begin errors++; $display("FAIL fwd_eflags_c got %h want 00000053", bus.eflags); end
        checks++; if (bus.CF_dataforwarded !== 1'b1 || bus.retired_count !== 32'd7) begin errors++; $display("FAIL fwd_arch cf/count got %b/%0d want 1/7", bus.CF_dataforwarded, bus.retired_count); end
    endtask

    task automatic test_ports();
        clear_inputs();
        bus.WB_V_next = 1; bus.WB_de_datasize_all_next = 2'd3;
        bus.WB_ex_ld_gpr1_wb_next = 1; bus.WB_ex_ld_gpr2_wb_next = 1; bus.WB_ld_gpr3_wb_next = 1;
        bus.WB_DR1_next = 1; bus.WB_DR2_next = 2; bus.WB_DR3_next = 6;
        bus.WB_RESULT_A_next = 32'hA1; bus.WB_RESULT_B_next = 32'hB2; bus.WB_RESULT_C_next = 32'hC3;
        tick();
        clear_inputs();
        #1;
        checks++; if ({bus.gpr_we1, bus.gpr_we2, bus.gpr_we3} !== 3'b111) begin errors++; $display("FAIL ports_we got %b want 111", {bus.gpr_we1, bus.gpr_we2, bus.gpr_we3}); end
        checks++; if (bus.gpr_sel2 !== 3'd2 || bus.gpr_sel3 !== 3'd6) begin errors++; $display("FAIL ports_sel got %0d/%0d want 2/6", bus.gpr_sel2, bus.gpr_sel3); end
        checks++; if (bus.gpr_data2 !== 32'hB2 || bus.gpr_data3 !== 32'hC3) begin errors++; $display("FAIL ports_data got %h/%h want 000000b2/000000c3", bus.gpr_data2, bus.gpr_data3); end
        checks++; if (bus.gpr_size !== 2'd2) begin errors++; $display("FAIL ports_size got %0d want 2", bus.gpr_size); end
        tick();
        checks++; if (bus.retired_count !== 32'd8) begin errors++; $display("FAIL ports_count got %0d want 8", bus.retired_count); end
    endtask

    task automatic test_reset_ack();
        clear_inputs();
        bus.WB_V_next = 1; bus.WB_ex_dcache_write_wb_next = 1; bus.WB_ADDRESS_next = 32'h3000;
        tick();
        clear_inputs();
        tick();
        rst = 1;
        bus.dcache_ack = 1;
        #1;
        checks++; if (bus.retire !== 1'b0 || bus.dcache_req !== 1'b1) begin errors++; $display("FAIL rstack_cycle retire/req got %b/%b want 0/1", bus.retire, bus.dcache_req); end
        tick();
        rst = 0;
        bus.dcache_ack = 0;
        #1;
        checks++; if (bus.dcache_req !== 1'b0 || bus.WB_stall !== 1'b0 || bus.retire !== 1'b0) begin errors++; $display("FAIL rstack_after req/stall/retire got %b/%b/%b want 0/0/0", bus.dcache_req, bus.WB_stall, bus.retire); end
        checks++; if (bus.retired_count !== 32'd0) begin errors++; $display("FAIL rstack_count got %0d want 0", bus.retired_count); end
        checks++; if (bus.eflags !== 32'h2 || bus.eip_commit !== 32'h0) begin errors++; $display("FAIL rstack_arch got %h/%h want 00000002/00000000", bus.eflags, bus.eip_commit); end
        tick();
        checks++; if (bus.dcache_req !== 1'b0) begin errors++; $display("FAIL rstack_idle req got %b want 0", bus.dcache_req); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_back_to_back();
        test_forward();
        test_ports();
        test_reset_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage, directly downstream of execute. Latches execute results into the WB latches and retires each valid instruction. Retirement means GPR write-back on up to three ports, a masked architectural EFLAGS update, and an optional dcache write using a req/ack handshake. While a dcache write is outstanding it holds WB_stall back to execute. It also drives CF/AF forwarding to the execute ALU.

Parameters:
EFLAGS_RESET, 32'h0000_0002, architectural EFLAGS value after reset (bit 1 reserved-one).
CNT_W, 32, width of retired-instruction counter.

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous, active-high reset
WB_V_next  in  1  valid from execute
WB_NEIP_next  in  32  next EIP of instruction
WB_NCS_next  in  16  next CS
WB_de_datasize_all_next  in  2  0=8b, 1=16b, 2=32b (3 treated as 32b)
WB_ex_ld_gpr1_wb_next, WB_ex_ld_gpr2_wb_next, WB_ld_gpr3_wb_next  in  1 each  GPR write requests
WB_ex_dcache_write_wb_next  in  1  dcache write request
WB_de_flags_affected_wb_next  in  7  mask [0]CF [1]PF [2]AF [3]ZF [4]SF [5]DF [6]OF
WB_RESULT_A_next, WB_RESULT_B_next, WB_RESULT_C_next  in  32 each  results for DR1/DR2/DR3; A is also the store data
WB_FLAGS_next  in  32  EFLAGS-format flags from execute
WB_ADDRESS_next  in  32  dcache write address
WB_DR1_next, WB_DR2_next, WB_DR3_next  in  3 each  GPR indices
dcache_ack  in  1  dcache accepted write this cycle
WB_stall  out  1  execute must hold; WB latches do not load
gpr_we1/2/3  out  1 each  GPR write enables
gpr_sel1/2/3  out  3 each  GPR indices
gpr_data1/2/3  out  32 each  write data
gpr_size  out  2  datasize for all ports
dcache_req  out  1  write request
dcache_addr  out  32  write address
dcache_data  out  32  write data
dcache_size  out  2  write size
eflags  out  32  architectural EFLAGS
eip_commit  out  32  EIP of last retired instruction
cs_commit  out  16  CS of last retired instruction
CF_dataforwarded, AF_dataforwarded  out  1 each  forwarded flags
retire  out  1  pulse in the cycle an instruction retires
retired_count  out  CNT_W  number of instructions retired

Behaviour:
- Reset (RST=1 at edge): clear V, FSM=IDLE, eflags=EFLAGS_RESET, eip_commit=0, cs_commit=0, retired_count=0. All write enables, req, retire and stall are 0 the cycle after. A pending dcache write is abandoned without retiring.
- WB latches load at an edge when !WB_stall. V loads WB_V_next. Non-V fields load unconditionally.
- FSM states:
  - IDLE: latched instruction valid with dcache_write → go to WAIT at the same edge the latches load.
  - WAIT: dcache_req=1. On dcache_ack → instruction retires this cycle, then return to IDLE. If the incoming latched instruction is also a write, go straight to WAIT again.
- WB_stall = (state==WAIT) & !dcache_ack. Combinational, so back-to-back stores lose no cycle beyond each ack.
- commit = V & (!dcache_write | (state==WAIT & dcache_ack)). retire = commit.
- gpr_weN = commit & ldN. Data and selectors come straight from the latches.
  - Sub-word merge is the regfile's job via gpr_size.
  - Two ports may name the same index: port 3 beats 2 beats 1. The regfile implements this; this block does not suppress any port.
- On a commit edge:
  - eflags[b] = WB_FLAGS[b] for each affected bit b in {0,2,4,6,7,10,11}; all other bits hold.
  - eip_commit / cs_commit update.
  - retired_count += 1, wrapping modulo 2^CNT_W.
- Forwarding is combinational. CF_dataforwarded = (V & mask[0]) ? WB_FLAGS[0] : eflags[0]. AF is the same with mask[2] and bit 4. Forwarding ignores stall state.
- Reset asserted together with dcache_ack: reset wins, no retire, counter stays 0.

Decomposition:
- Shared package holds:
  - datasize encodings;
  - flags_affected bit indices;
  - EFLAGS bit positions (CF=0, PF=2, AF=4, ZF=6, SF=7, DF=10, OF=11);
  - FSM state encoding.
- One sub-module: wb_flags_update. It holds the masked merge of WB_FLAGS into eflags plus the CF/AF forward muxes; it has no internal state of its own.

Test Plan:
- Reset: hold RST 2 cycles → eflags=0x00000002, retired_count=0, WB_stall=0, all we/req=0.
- ALU op, no store: V=1, ld_gpr1=1, DR1=3, A=0x12345678, mask=7'b0001001, FLAGS=0x41 → gpr_we1=1, sel1=3, data1=0x12345678. Next cycle eflags=0x00000043 (CF and ZF set, bit 1 kept), retired_count=1.
- Store with 3-cycle ack delay: dcache_write=1, ADDRESS=0x1000, A=0xDEADBEEF → dcache_req high 3 cycles, WB_stall=1 for 2 cycles then 0 in the ack cycle, retire exactly once.
- Back-to-back stores, ack every cycle → two retires on consecutive cycles, WB_stall never 1.
- Forwarding: latched V=1, mask[0]=1, FLAGS[0]=1, eflags[0]=0 → CF_dataforwarded=1. Same case with V=0 → CF_dataforwarded=0.
- RST raised during WAIT together with dcache_ack → no retire, retired_count=0, FSM IDLE, dcache_req=0 next cycle.
